regfile16_write: RTL and testbench

REGFILE16_WRITE -- requirements
Module: regfile16_write

---
 rtl/regfile16_write_pkg.sv | 14 +
 rtl/regfile16_write_if.sv | 26 ++
 rtl/regfile16_write_decoder4_16.sv | 34 +++
 rtl/regfile16_write.sv | 85 ++++++++
 tb/tb_regfile16_write.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/regfile16_write_pkg.sv
// rtl/regfile16_write_pkg.sv - shared constants and types for the 16-entry write-side register file
package regfile16_write_pkg;

    localparam int NUM_REGS         = 16;
    localparam int ADDR_W           = 4;
    localparam int ZERO_REG_DEFAULT = 15;
    localparam int COUNT_W          = 8;
    localparam logic [COUNT_W-1:0] COUNT_MAX = 8'd255;

    typedef logic [ADDR_W-1:0]   addr_t;
    typedef logic [NUM_REGS-1:0] onehot_t;
    typedef logic [COUNT_W-1:0]  count_t;

endpackage

// File: rtl/regfile16_write_if.sv
// rtl/regfile16_write_if.sv - write-port and status bundle of the register file
// master: drives wr_en/wr_addr/wr_data/clr_all, observes regs_out/wr_onehot/wr_count
// slave : the register file itself
interface regfile16_write_if
    import regfile16_write_pkg::*;
#(
    parameter int WIDTH = 64
);
    logic                      wr_en;
    addr_t                     wr_addr;
    logic [WIDTH-1:0]          wr_data;
    logic                      clr_all;
    logic [NUM_REGS*WIDTH-1:0] regs_out;
    onehot_t                   wr_onehot;
    count_t                    wr_count;

    modport master (
        output wr_en, wr_addr, wr_data, clr_all,
        input  regs_out, wr_onehot, wr_count
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, clr_all,
        output regs_out, wr_onehot, wr_count
    );
endinterface

// File: rtl/regfile16_write_decoder4_16.sv
// rtl/regfile16_write_decoder4_16.sv - combinational 4:16 one-hot decoder built from two 2:4 decoders
// in_i  : 4-bit index
// en_i  : global enable; all outputs low when 0
// out_o : one-hot of in_i when en_i=1
module decoder4_16
    import regfile16_write_pkg::*;
(
    input  addr_t   in_i,
    input  logic    en_i,
    output onehot_t out_o
);
    logic [3:0] hi_dec;
    logic [3:0] lo_dec;

    // Enable is folded into the high decoder so an undriven index with en_i=0
    // still resolves every output to 0.
    always_comb begin
        hi_dec = 4'b0000;
        lo_dec = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            hi_dec[k] = en_i & (in_i[3:2] == 2'(k));
            lo_dec[k] = (in_i[1:0] == 2'(k));
        end
    end

    always_comb begin
        out_o = '0;
        for (int h = 0; h < 4; h++) begin
            for (int l = 0; l < 4; l++) begin
                out_o[h*4 + l] = hi_dec[h] & lo_dec[l];
            end
        end
    end
endmodule

// File: rtl/regfile16_write.sv
// rtl/regfile16_write.sv - 16 x WIDTH register file write side with hardwired-zero entry
// clk     : single rising-edge clock
// reset_n : asynchronous active-low reset of entries, wr_onehot and wr_count
// bus     : slave side of regfile16_write_if (write port, clear, flattened contents, status)
module regfile16_write
    import regfile16_write_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int ZERO_REG = ZERO_REG_DEFAULT
)(
    input  logic                     clk,
    input  logic                     reset_n,
    regfile16_write_if.slave         bus
);
    localparam onehot_t ZERO_MASK = onehot_t'(1) << ZERO_REG;

    onehot_t dec_onehot;
    onehot_t wr_sel;
    logic    commit;

    onehot_t wr_onehot_d, wr_onehot_q;
    count_t  wr_count_d,  wr_count_q;

    decoder4_16 u_dec (
        .in_i  (bus.wr_addr),
        .en_i  (bus.wr_en),
        .out_o (dec_onehot)
    );

    // Writes to the zero entry are dropped entirely, and clear wins over write.
    // Deriving commit from the gated one-hot keeps an unknown address with
    // wr_en=0 from reaching any state.
    assign wr_sel = bus.clr_all ? '0 : (dec_onehot & ~ZERO_MASK);
    assign commit = |wr_sel;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_slice
        if (i == ZERO_REG) begin : g_zero
            assign bus.regs_out[i*WIDTH +: WIDTH] = '0;
        end else begin : g_reg
            logic [WIDTH-1:0] slice_d, slice_q;

            always_comb begin
                slice_d = slice_q;
                if (bus.clr_all) begin
                    slice_d = '0;
                end else if (wr_sel[i]) begin
                    slice_d = bus.wr_data;
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    slice_q <= '0;
                end else begin
                    slice_q <= slice_d;
                end
            end

            assign bus.regs_out[i*WIDTH +: WIDTH] = slice_q;
        end
    end

    always_comb begin
        wr_onehot_d = wr_sel;
        wr_count_d  = wr_count_q;
        if (bus.clr_all) begin
            wr_count_d = '0;
        end else if (commit && (wr_count_q != COUNT_MAX)) begin
            wr_count_d = wr_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_onehot_q <= '0;
            wr_count_q  <= '0;
        end else begin
            wr_onehot_q <= wr_onehot_d;
            wr_count_q  <= wr_count_d;
        end
    end

    assign bus.wr_onehot = wr_onehot_q;
    assign bus.wr_count  = wr_count_q;
endmodule

// File: tb/tb_regfile16_write.sv
// tb/tb_regfile16_write.sv - self-checking bench for regfile16_write
module tb_regfile16_write;
    localparam int W  = 64;
    localparam int ZR = 15;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    regfile16_write_if #(.WIDTH(W)) bus ();

    regfile16_write #(.WIDTH(W), .ZERO_REG(ZR)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int tests = 0;
    int fails = 0;

    logic [W-1:0] m_regs [16];
    logic [15:0]  m_onehot;
    int           m_count;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_onehot = 16'h0;
        m_count  = 0;
    endfunction

    function automatic void model_edge();
        int a;
        if (!reset_n) begin
            model_reset();
        end else if (bus.clr_all) begin
            model_reset();
        end else if (bus.wr_en && (int'(bus.wr_addr) != ZR)) begin
            a = int'(bus.wr_addr);
            m_regs[a] = bus.wr_data;
            m_onehot  = 16'h0;
            m_onehot[a] = 1'b1;
            m_count   = (m_count >= 255) ? 255 : m_count + 1;
        end else begin
            m_onehot = 16'h0;
        end
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("%s.entry%0d", tag, i), bus.regs_out[i*W +: W], m_regs[i]);
        end
        chk({tag, ".onehot"}, W'(bus.wr_onehot), W'(m_onehot));
        chk({tag, ".count"},  W'(bus.wr_count),  W'(m_count));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic en, input logic [3:0] addr, input logic [W-1:0] data, input logic clr);
        bus.wr_en   = en;
        bus.wr_addr = addr;
        bus.wr_data = data;
        bus.clr_all = clr;
    endtask

    initial begin
        drive(1'b0, 4'd0, '0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset_state");
        #3 reset_n = 1'b1;
        #1 chk_all("reset_release");
        tick();

        // basic write
        drive(1'b1, 4'd3, 64'hDEAD_BEEF, 1'b0);
        tick();
        chk_all("basic_write");
        chk("basic_entry3", bus.regs_out[3*W +: W], 64'hDEAD_BEEF);
        chk("basic_onehot", W'(bus.wr_onehot), 64'h0008);
        chk("basic_count",  W'(bus.wr_count),  64'd1);

        // zero entry
        drive(1'b1, 4'd15, 64'h1234, 1'b0);
        tick();
        chk_all("zero_write");
        chk("zero_onehot", W'(bus.wr_onehot), 64'h0);

        // back-to-back
        drive(1'b1, 4'd5, 64'h11, 1'b0);
        tick();
        chk_all("b2b_first");
        chk("b2b_onehot1", W'(bus.wr_onehot), 64'h0020);
        drive(1'b1, 4'd5, 64'h22, 1'b0);
        tick();
        chk_all("b2b_second");
        chk("b2b_entry5", bus.regs_out[5*W +: W], 64'h22);
        chk("b2b_count",  W'(bus.wr_count), 64'd3);

        // idle with X address
        drive(1'b0, 4'bxxxx, 64'hFFFF_0000, 1'b0);
        tick();
        chk_all("idle_xaddr");

        // clear priority
        drive(1'b1, 4'd0, 64'hFF, 1'b1);
        tick();
        chk_all("clear_prio");
        chk("clear_count", W'(bus.wr_count), 64'd0);

        // randomized traffic
        for (int n = 0; n < 200; n++) begin
            drive(($urandom_range(3, 0) != 0), 4'($urandom_range(15, 0)),
                  {$urandom, $urandom}, ($urandom_range(31, 0) == 0));
            tick();
            chk_all($sformatf("rand%0d", n));
        end

        // saturation
        drive(1'b0, 4'd0, '0, 1'b1);
        tick();
        for (int n = 0; n < 300; n++) begin
            drive(1'b1, 4'(n % 15), {32'(n), $urandom}, 1'b0);
            tick();
        end
        chk_all("saturate");
        chk("saturate_count", W'(bus.wr_count), 64'd255);
        drive(1'b1, 4'd2, 64'hABCD, 1'b0);
        tick();
        chk_all("saturate_hold");

        // asynchronous reset mid-cycle with a write pending
        drive(1'b1, 4'd7, 64'h7777, 1'b0);
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        chk_all("async_reset");
        tick();
        chk_all("reset_held_write");
        drive(1'b1, 4'd9, 64'h9999, 1'b0);
        #3 reset_n = 1'b1;
        #1 chk_all("deassert_no_write");
        tick();
        chk_all("first_after_reset");
        chk("first_after_reset_count", W'(bus.wr_count), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
